// File: rtl/drp_resp_pkg.sv
// Shared widths, FSM state type and register-file reset image for the DRP responder.
package drp_resp_pkg;

    localparam int DRP_AW     = 5;
    localparam int DRP_DW     = 16;
    localparam int DRP_DEPTH  = 1 << DRP_AW;
    localparam int DRP_LAT_CW = 4;

    typedef logic [DRP_DW-1:0] drp_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } drp_state_t;

    // Power-on image; 0x08 and 0x14 hold the default divider words.
    localparam drp_word_t DRP_RST_VAL [DRP_DEPTH] = '{
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h1041, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1041, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

endpackage

// File: rtl/drp_lock_timer.sv
// Emulated PLL lock: counts clean edges after RST_PLL drops and raises LOCKED once
// LOCK_CYCLES edges have elapsed; the counter saturates.
module drp_lock_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic CLK,
    input  logic RSTX,
    input  logic RST_PLL,
    output logic LOCKED
);

    localparam int             CW       = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0]  LOCK_MAX = CW'(LOCK_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_locked;

    always_comb begin
        w_cnt_next = r_cnt;
        if (RST_PLL) begin
            w_cnt_next = '0;
        end else if (r_cnt != LOCK_MAX) begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_locked <= (w_cnt_next == LOCK_MAX);
        end
    end

    assign LOCKED = r_locked;

endmodule

// File: rtl/drp_responder.sv
// DRP slave stand-in for a PLL: 32x16 register file, fixed-latency DRDY, lock emulation.
// Optional sticky protocol-error flag enabled by defining DRP_RESP_ERR_EN.
module drp_responder
    import drp_resp_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RSTX,
    input  logic              DEN,
    input  logic              DWE,
    input  logic [DRP_AW-1:0] DADDR,
    input  logic [DRP_DW-1:0] DI,
    input  logic              RST_PLL,
    output logic [DRP_DW-1:0] DO,
    output logic              DRDY,
    output logic              LOCKED
`ifdef DRP_RESP_ERR_EN
    ,
    output logic              PROT_ERR
`endif
);

    drp_state_t            r_state;
    drp_state_t            w_state_next;
    logic [DRP_LAT_CW-1:0] r_cnt;
    logic [DRP_LAT_CW-1:0] w_cnt_next;
    logic                  w_accept;
    logic [DRP_AW-1:0]     r_addr;
    logic                  r_we;
    logic                  r_drdy;
    drp_word_t             r_do;
    drp_word_t             r_mem [DRP_DEPTH];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (DEN) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = DRP_LAT_CW'(LATENCY - 1);
                    w_state_next = (LATENCY == 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - DRP_LAT_CW'(1);
                if (r_cnt <= DRP_LAT_CW'(1)) begin
                    w_state_next = ACK;
                end
            end
            ACK: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // DRDY/DO trail the ACK state by one edge so every output leaves a flop.
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_drdy  <= 1'b0;
            r_do    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_addr <= DADDR;
                r_we   <= DWE;
            end
            r_drdy <= (r_state == ACK);
            r_do   <= ((r_state == ACK) && !r_we) ? r_mem[r_addr] : '0;
        end
    end

    // Writes commit on the accepting edge, so any later read sees them.
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            for (int i = 0; i < DRP_DEPTH; i++) begin
                r_mem[i] <= DRP_RST_VAL[i];
            end
        end else if (w_accept && DWE) begin
            r_mem[DADDR] <= DI;
        end
    end

    drp_lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .CLK     (CLK),
        .RSTX    (RSTX),
        .RST_PLL (RST_PLL),
        .LOCKED  (LOCKED)
    );

`ifdef DRP_RESP_ERR_EN
    logic r_prot_err;

    // Strobes while busy, and writes to a running PLL, both count as violations.
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            r_prot_err <= 1'b0;
        end else if ((DEN && (r_state != IDLE)) || (w_accept && DWE && !RST_PLL)) begin
            r_prot_err <= 1'b1;
        end
    end

    assign PROT_ERR = r_prot_err;
`endif

    assign DRDY = r_drdy;
    assign DO   = r_do;

endmodule

// File: tb/tb_drp_responder.sv
// Bench for drp_responder: three instances (LATENCY 2, 1, 15) checked every cycle
// against an edge-count model, plus directed accesses with literal expectations.
`timescale 1ns/1ps
module tb_drp_responder;

    localparam int NI = 3;
    localparam int LC = 16;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstx;
    logic        rst_pll;
    logic        den   [NI];
    logic        dwe   [NI];
    logic [4:0]  daddr [NI];
    logic [15:0] di    [NI];
    logic [15:0] dout  [NI];
    logic        drdy  [NI];
    logic        locked[NI];
`ifdef DRP_RESP_ERR_EN
    logic        prot  [NI];
`endif

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        drp_responder #(
            .LATENCY     (lat_of(gi)),
            .LOCK_CYCLES (LC)
        ) u_dut (
            .CLK      (clk),
            .RSTX     (rstx),
            .DEN      (den[gi]),
            .DWE      (dwe[gi]),
            .DADDR    (daddr[gi]),
            .DI       (di[gi]),
            .RST_PLL  (rst_pll),
            .DO       (dout[gi]),
            .DRDY     (drdy[gi]),
            .LOCKED   (locked[gi])
`ifdef DRP_RESP_ERR_EN
            ,
            .PROT_ERR (prot[gi])
`endif
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an access accepted at edge N acks at N+L and frees the slave at N+L+1.
    int          e = 0;
    bit          started = 1'b0;
    logic [15:0] mem     [NI][32];
    int          free_at [NI];
    int          pend_edge [NI];
    bit          pend    [NI];
    logic [15:0] pend_do [NI];
    bit          m_prot  [NI];
    int          lock_cnt = 0;

    always @(posedge clk) begin
        e++;
        if (!rstx) begin
            started  = 1'b1;
            lock_cnt = 0;
            for (int k = 0; k < NI; k++) begin
                for (int a = 0; a < 32; a++) mem[k][a] = 16'h0000;
                mem[k][8]    = 16'h1041;
                mem[k][20]   = 16'h1041;
                free_at[k]   = 0;
                pend[k]      = 1'b0;
                pend_edge[k] = 0;
                pend_do[k]   = 16'h0000;
                m_prot[k]    = 1'b0;
            end
        end else begin
            if (rst_pll) lock_cnt = 0;
            else if (lock_cnt < LC) lock_cnt = lock_cnt + 1;
            for (int k = 0; k < NI; k++) begin
                if (den[k]) begin
                    if (e >= free_at[k]) begin
                        pend[k]      = 1'b1;
                        pend_edge[k] = e + lat_of(k);
                        free_at[k]   = e + lat_of(k) + 1;
                        pend_do[k]   = dwe[k] ? 16'h0000 : mem[k][daddr[k]];
                        if (dwe[k]) begin
                            mem[k][daddr[k]] = di[k];
                            if (!rst_pll) m_prot[k] = 1'b1;
                        end
                    end else begin
                        m_prot[k] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NI; k++) begin
                bit exp_rdy;
                exp_rdy = pend[k] && (pend_edge[k] == e);
                check($sformatf("model_drdy[%0d] e=%0d", k, e), {31'b0, drdy[k]}, {31'b0, exp_rdy});
                check($sformatf("model_do[%0d] e=%0d", k, e), {16'b0, dout[k]},
                      {16'b0, (exp_rdy ? pend_do[k] : 16'h0000)});
                check($sformatf("model_locked[%0d] e=%0d", k, e), {31'b0, locked[k]},
                      {31'b0, (lock_cnt >= LC)});
`ifdef DRP_RESP_ERR_EN
                check($sformatf("model_prot[%0d] e=%0d", k, e), {31'b0, prot[k]}, {31'b0, m_prot[k]});
`endif
            end
        end
    end

    // Issued at a negedge; returns at the negedge just after the expected ack.
    task automatic access(input int k, input bit we, input logic [4:0] a,
                          input logic [15:0] d, input logic [15:0] exp_do);
        int l;
        l = lat_of(k);
        den[k] = 1'b1; dwe[k] = we; daddr[k] = a; di[k] = d;
        @(negedge clk);
        den[k] = 1'b0; dwe[k] = 1'b0;
        for (int i = 1; i <= l; i++) begin
            @(negedge clk);
            if (i < l) begin
                check($sformatf("drdy_early[%0d] a=%h", k, a), {31'b0, drdy[k]}, 32'd0);
            end else begin
                check($sformatf("drdy_at_lat[%0d] a=%h", k, a), {31'b0, drdy[k]}, 32'd1);
                check($sformatf("do_ack[%0d] a=%h", k, a), {16'b0, dout[k]}, {16'b0, exp_do});
            end
        end
        $display("[TB] inst %0d %s addr=%h data=%h ack DO=%h", k, we ? "WR" : "RD", a, d, dout[k]);
    endtask

    initial begin
        int pulses;
        rstx = 1'b0;
        rst_pll = 1'b0;
        for (int k = 0; k < NI; k++) begin
            den[k] = 1'b0; dwe[k] = 1'b0; daddr[k] = 5'h00; di[k] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        rstx = 1'b1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_drdy[%0d]", k), {31'b0, drdy[k]}, 32'd0);
            check($sformatf("rst_do[%0d]", k), {16'b0, dout[k]}, 32'd0);
            check($sformatf("rst_locked[%0d]", k), {31'b0, locked[k]}, 32'd0);
        end
        repeat (15) @(negedge clk);
        check("lock_after_15", {31'b0, locked[0]}, 32'd0);
        @(negedge clk);
        check("lock_after_16", {31'b0, locked[0]}, 32'd1);
        $display("[TB] reset released, LOCKED=%0b after 16 edges", locked[0]);

        access(0, 1'b0, 5'h08, 16'h0000, 16'h1041);
        access(0, 1'b0, 5'h00, 16'h0000, 16'h0000);
`ifdef DRP_RESP_ERR_EN
        check("prot_clean", {31'b0, prot[0]}, 32'd0);
`endif

        den[0] = 1'b1; dwe[0] = 1'b0; daddr[0] = 5'h14;
        @(negedge clk);
        den[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 5'h03; di[0] = 16'hAAAA;
        @(negedge clk);
        den[0] = 1'b0; dwe[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (drdy[0] === 1'b1) begin
                pulses++;
                check("ignored_den_do", {16'b0, dout[0]}, 32'h1041);
            end
            @(negedge clk);
        end
        check("ignored_den_pulses", pulses, 32'd1);
        $display("[TB] inst 0 DEN during WAIT: %0d DRDY pulse(s)", pulses);
`ifdef DRP_RESP_ERR_EN
        check("prot_set", {31'b0, prot[0]}, 32'd1);
`endif
        access(0, 1'b0, 5'h03, 16'h0000, 16'h0000);

        access(0, 1'b1, 5'h1F, 16'hBEEF, 16'h0000);
        access(0, 1'b0, 5'h1F, 16'h0000, 16'hBEEF);

        check("lock_before_pulse", {31'b0, locked[0]}, 32'd1);
        rst_pll = 1'b1;
        @(negedge clk);
        check("lock_drop", {31'b0, locked[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_pll = 1'b0;
        repeat (15) @(negedge clk);
        check("relock_15", {31'b0, locked[0]}, 32'd0);
        @(negedge clk);
        check("relock_16", {31'b0, locked[0]}, 32'd1);
        $display("[TB] RST_PLL pulse: relocked=%0b", locked[0]);

        den[0] = 1'b1; dwe[0] = 1'b1; daddr[0] = 5'h02; di[0] = 16'h1234;
        @(negedge clk);
        den[0] = 1'b0; dwe[0] = 1'b0;
        rstx = 1'b0;
        @(negedge clk);
        rstx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("no_drdy_after_rst", {31'b0, drdy[0]}, 32'd0);
            @(negedge clk);
        end
        $display("[TB] inst 0 reset during WAIT, pending ack dropped");
        access(0, 1'b0, 5'h02, 16'h0000, 16'h0000);

        for (int k = 1; k < NI; k++) begin
            logic [15:0] v;
            v = 16'h5A50 + 16'(k);
            access(k, 1'b1, 5'h05, v, 16'h0000);
            access(k, 1'b0, 5'h05, 16'h0000, v);
            access(k, 1'b0, 5'h14, 16'h0000, 16'h1041);
            access(k, 1'b1, 5'h1F, 16'hC3C3, 16'h0000);
            access(k, 1'b0, 5'h1F, 16'h0000, 16'hC3C3);
            access(k, 1'b0, 5'h08, 16'h0000, 16'h1041);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
